// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - source, FFT and result streams plus status of the frame sequencer
interface fft_frame_sequencer_if;
  logic        start_in;
  logic [7:0]  src_data_in;
  logic        src_valid_in;
  logic        src_last_in;
  logic        src_ready_out;
  logic [31:0] fft_tdata_out;
  logic        fft_tvalid_out;
  logic        fft_tlast_out;
  logic        fft_tready_in;
  logic        res_tvalid_in;
  logic        res_tready_in;
  logic        res_tlast_in;
  logic [7:0]  frames_out;
  logic        busy_out;
  logic        done_out;
  logic        trunc_out;

  // master is the sequencer itself; slave is the recorder/FFT/detector side
  modport master (
    input  start_in, src_data_in, src_valid_in, src_last_in, fft_tready_in,
           res_tvalid_in, res_tready_in, res_tlast_in,
    output src_ready_out, fft_tdata_out, fft_tvalid_out, fft_tlast_out,
           frames_out, busy_out, done_out, trunc_out
  );

  modport slave (
    output start_in, src_data_in, src_valid_in, src_last_in, fft_tready_in,
           res_tvalid_in, res_tready_in, res_tlast_in,
    input  src_ready_out, fft_tdata_out, fft_tvalid_out, fft_tlast_out,
           frames_out, busy_out, done_out, trunc_out
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - cuts recorded samples into zero-padded FFT frames and tracks result drain
module fft_frame_sequencer #(
  parameter int FRAME_LEN  = 1024,
  parameter int MAX_FRAMES = 16
) (
  input logic                   clk_in,
  input logic                   rst_in,
  fft_frame_sequencer_if.master bus
);
  localparam int             IW          = $clog2(FRAME_LEN);
  localparam logic [IW-1:0]  LAST_IDX    = IW'(FRAME_LEN - 1);
  localparam logic [7:0]     FINAL_FRAME = 8'(MAX_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FILL, PAD, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    res_cnt;
  logic [7:0]    res_next;
  logic [7:0]    frames_inc;
  logic          load_ok;
  logic          src_take;
  logic          at_last;
  logic          res_last_hs;

  assign load_ok           = !bus.fft_tvalid_out || bus.fft_tready_in;
  assign bus.src_ready_out = (state == FILL) && load_ok;
  assign src_take          = bus.src_ready_out && bus.src_valid_in;
  assign at_last           = (idx == LAST_IDX);
  assign res_last_hs       = bus.res_tvalid_in && bus.res_tready_in && bus.res_tlast_in;
  assign res_next          = res_cnt + {7'd0, res_last_hs};
  assign frames_inc        = bus.frames_out + {7'd0, bus.frames_out != 8'hFF};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= IDLE;
      idx                <= '0;
      res_cnt            <= '0;
      bus.fft_tdata_out  <= '0;
      bus.fft_tvalid_out <= 1'b0;
      bus.fft_tlast_out  <= 1'b0;
      bus.frames_out     <= '0;
      bus.busy_out       <= 1'b0;
      bus.done_out       <= 1'b0;
      bus.trunc_out      <= 1'b0;
    end else begin
      bus.done_out <= 1'b0;
      // an accepted or empty register drops valid unless a new beat is loaded below
      if (load_ok) begin
        bus.fft_tvalid_out <= 1'b0;
        bus.fft_tlast_out  <= 1'b0;
      end
      if (state != IDLE) begin
        res_cnt <= res_next;
      end

      case (state)
        IDLE: begin
          if (bus.start_in) begin
            idx            <= '0;
            res_cnt        <= '0;
            bus.frames_out <= '0;
            bus.trunc_out  <= 1'b0;
            bus.busy_out   <= 1'b1;
            state          <= FILL;
          end
        end
        FILL: begin
          if (src_take) begin
            bus.fft_tdata_out  <= {16'h0000, bus.src_data_in, 8'h00};
            bus.fft_tvalid_out <= 1'b1;
            bus.fft_tlast_out  <= at_last;
            idx                <= idx + 1'b1;
            if (at_last) begin
              bus.frames_out <= frames_inc;
            end
            if (bus.src_last_in) begin
              state <= at_last ? DRAIN : PAD;
            end else if (at_last && bus.frames_out == FINAL_FRAME) begin
              bus.trunc_out <= 1'b1;
              state         <= DRAIN;
            end
          end
        end
        PAD: begin
          if (load_ok) begin
            bus.fft_tdata_out  <= '0;
            bus.fft_tvalid_out <= 1'b1;
            bus.fft_tlast_out  <= at_last;
            idx                <= idx + 1'b1;
            if (at_last) begin
              bus.frames_out <= frames_inc;
              state          <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // look at next-cycle values so done follows the final handshake by one cycle
          if (res_next == bus.frames_out && load_ok) begin
            bus.done_out <= 1'b1;
            bus.busy_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - randomized self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;
  localparam int FRAME_LEN  = 8;
  localparam int MAX_FRAMES = 4;
  localparam int CAP        = FRAME_LEN * MAX_FRAMES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sequencer_if bus ();

  fft_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .MAX_FRAMES(MAX_FRAMES)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  byte         src_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          exp_acc, exp_frames;
  bit          exp_trunc;
  int          acc_cnt, res_sent, last_res_cyc;
  int          cyc = 0;
  int          tlast_seen, done_cnt, done_cyc;
  bit          mon_on = 1'b0;
  bit          gen_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mon_on) begin
      got_q.delete();
      tlast_seen = 0;
      done_cnt   = 0;
      done_cyc   = -1;
    end else begin
      if (bus.fft_tvalid_out && bus.fft_tready_in) begin
        got_q.push_back({bus.fft_tlast_out, bus.fft_tdata_out});
        if (bus.fft_tlast_out) tlast_seen++;
      end
      if (bus.done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Expected FFT stream: accepted samples, zero-padded to whole frames, tlast every FRAME_LEN beats
  task automatic build_model(input bit has_last);
    int n, total;
    logic [7:0] s;
    n = src_q.size();
    exp_q.delete();
    exp_trunc  = !(has_last && n <= CAP);
    exp_acc    = exp_trunc ? CAP : n;
    total      = ((exp_acc + FRAME_LEN - 1) / FRAME_LEN) * FRAME_LEN;
    exp_frames = total / FRAME_LEN;
    for (int i = 0; i < total; i++) begin
      s = (i < exp_acc) ? src_q[i] : 8'h00;
      exp_q.push_back({(i % FRAME_LEN) == FRAME_LEN - 1, 16'h0000, s, 8'h00});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tdata"},  bus.fft_tdata_out, 0);
    check_eq({tag, "_tvalid"}, bus.fft_tvalid_out, 0);
    check_eq({tag, "_tlast"},  bus.fft_tlast_out, 0);
    check_eq({tag, "_ready"},  bus.src_ready_out, 0);
    check_eq({tag, "_frames"}, bus.frames_out, 0);
    check_eq({tag, "_busy"},   bus.busy_out, 0);
    check_eq({tag, "_done"},   bus.done_out, 0);
    check_eq({tag, "_trunc"},  bus.trunc_out, 0);
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    check_eq("busy_before_start", bus.busy_out, 0);
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    check_eq("busy_rise", bus.busy_out, 1);
  endtask

  task automatic drive_src(input bit has_last, input bit mid_start);
    bit acc;
    int w;
    acc_cnt = 0;
    for (int i = 0; i < src_q.size(); i++) begin
      acc = 1'b0;
      w   = 0;
      bus.src_data_in  = src_q[i];
      bus.src_last_in  = has_last && (i == src_q.size() - 1);
      bus.src_valid_in = 1'b1;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = bus.src_ready_out;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) break;
      acc_cnt++;
      if (mid_start && acc_cnt == 10) begin
        bus.src_valid_in = 1'b0;
        bus.start_in     = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        check_eq("mid_start_frames", bus.frames_out, 1);
        check_eq("mid_start_busy", bus.busy_out, 1);
      end
    end
    bus.src_valid_in = 1'b0;
    bus.src_last_in  = 1'b0;
  endtask

  task automatic set_res(input bit v, input bit l, input bit r);
    bus.res_tvalid_in = v;
    bus.res_tlast_in  = l;
    bus.res_tready_in = r;
  endtask

  // Tone detector stand-in: per submitted frame, one non-last beat, one stalled last, then the real last
  task automatic gen_results(input int nres);
    int budget;
    budget   = 0;
    res_sent = 0;
    while (res_sent < nres && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      if (tlast_seen > res_sent) begin
        set_res(1, 0, 1); @(posedge clk); #1;
        set_res(1, 1, 0); @(posedge clk); #1;
        set_res(1, 1, 1); @(posedge clk); #1;
        last_res_cyc = cyc;
        set_res(0, 0, 0);
        res_sent++;
        budget = 0;
      end
    end
    gen_done = 1'b1;
  endtask

  task automatic run(input string name, input bit has_last, input bit rnd_ready, input bit mid_start);
    logic [32:0] g;
    build_model(has_last);
    mon_on   = 1'b0;
    gen_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_on = 1'b1;
    bus.fft_tready_in = 1'b1;
    do_start();
    fork
      drive_src(has_last, mid_start);
      gen_results(exp_frames);
      begin
        while (!gen_done) begin
          @(posedge clk); #1;
          bus.fft_tready_in = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        bus.fft_tready_in = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check_eq({name, "_results_sent"}, res_sent, exp_frames);
    check_eq({name, "_accepted"}, acc_cnt, exp_acc);
    check_eq({name, "_beat_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      check_eq($sformatf("%s_beat%0d", name, i), g, exp_q[i]);
    end
    check_eq({name, "_frames"}, bus.frames_out, exp_frames);
    check_eq({name, "_trunc"}, bus.trunc_out, exp_trunc);
    check_eq({name, "_done_pulses"}, done_cnt, 1);
    check_eq({name, "_done_cycle"}, done_cyc, last_res_cyc);
    check_eq({name, "_busy_end"}, bus.busy_out, 0);
    mon_on = 1'b0;
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(byte'($urandom));
  endtask

  task automatic fill_count(input int n);
    src_q.delete();
    for (int i = 1; i <= n; i++) src_q.push_back(byte'(i));
  endtask

  initial begin
    bus.start_in      = 1'b0;
    bus.src_data_in   = '0;
    bus.src_valid_in  = 1'b0;
    bus.src_last_in   = 1'b0;
    bus.fft_tready_in = 1'b1;
    set_res(0, 0, 0);
    #1;
    check_reset_outputs("por");
    #21;
    rst_n = 1'b1;

    fill_count(8);
    run("s1_full", 1, 0, 0);

    src_q.delete();
    src_q.push_back(-1);
    src_q.push_back(2);
    src_q.push_back(-3);
    run("s2_pad", 1, 0, 0);

    fill_random(20);
    run("s3_stall", 1, 1, 0);

    fill_random(40);
    run("s4_trunc", 0, 1, 0);

    fill_random(20);
    run("s5_midstart", 1, 0, 1);

    fill_random(CAP);
    run("edge_cap", 1, 1, 0);

    fill_random(16);
    run("edge_two", 1, 0, 0);

    for (int k = 0; k < 4; k++) begin
      fill_random(int'($urandom_range(40, 1)));
      run($sformatf("rnd%0d", k), 1, 1, 0);
    end

    bus.fft_tready_in = 1'b1;
    fill_count(5);
    do_start();
    drive_src(0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    fill_count(8);
    run("s6_after_reset", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
